// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter_pkg
//   Shared constants for the Wishbone round-robin arbiter: master count and
//   grant FSM state encodings.
package wb_rr_arbiter_pkg;

    localparam int unsigned NMASTERS = 4;

    // Grant FSM encodings
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
//   Combinational 4-way round-robin priority picker. Returns the first
//   requester at or after ptr, searching upward modulo 4.
// Ports:
//   req       in   4  request vector
//   ptr       in   2  highest-priority index this round
//   gnt_next  out  4  one-hot winner (0 when no request)
//   idx       out  2  binary index of the winner (0 when no request)
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt_next,
    output logic [1:0] idx
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        gnt_next = '0;
        idx      = '0;
        cand     = '0;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // 2-bit add wraps naturally, giving the mod-4 search order
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found          = 1'b1;
                gnt_next[cand] = 1'b1;
                idx            = cand;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Shares one Wishbone slave among 4 masters with round-robin arbitration.
//   The grant is held for the whole CYC so bursts and RMW stay atomic; a
//   per-transfer watchdog answers a stalled slave with ERR.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_adr_i/m_dat_i   master address / write data, master k at slice k
//   m_sel_i, m_we_i   master byte selects / write enables
//   m_cyc_i, m_stb_i  master cycle / strobe
//   m_dat_o           slave read data broadcast to every master
//   m_ack_o, m_err_o  per-master ack / watchdog error
//   s_*_o             muxed request toward the slave
//   s_dat_i, s_ack_i  slave read data / ack
//   gnt_o             one-hot registered grant
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int unsigned adr_width      = 32,
    parameter int unsigned timeout_cycles = 1024,
    parameter int unsigned cnt_width      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NMASTERS*adr_width-1:0]  m_adr_i,
    input  logic [NMASTERS*32-1:0]         m_dat_i,
    input  logic [NMASTERS*4-1:0]          m_sel_i,
    input  logic [NMASTERS-1:0]            m_we_i,
    input  logic [NMASTERS-1:0]            m_cyc_i,
    input  logic [NMASTERS-1:0]            m_stb_i,
    output logic [31:0]                    m_dat_o,
    output logic [NMASTERS-1:0]            m_ack_o,
    output logic [NMASTERS-1:0]            m_err_o,
    output logic [adr_width-1:0]           s_adr_o,
    output logic [31:0]                    s_dat_o,
    output logic [3:0]                     s_sel_o,
    output logic                           s_we_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    input  logic [31:0]                    s_dat_i,
    input  logic                           s_ack_i,
    output logic [NMASTERS-1:0]            gnt_o
);

    // Watchdog compare value; meaningless (and unused) when disabled.
    localparam logic [cnt_width-1:0] WdLast   = cnt_width'(timeout_cycles - 1);
    localparam bit                   WdEnable = (timeout_cycles != 0);

    logic [0:0]           state_q, state_d;
    logic [3:0]           gnt_q, gnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [cnt_width-1:0] wd_cnt_q, wd_cnt_d;

    logic [3:0] pick_gnt;
    logic [1:0] pick_idx;
    logic       in_grant;
    logic       gnt_cyc;
    logic       gnt_stb;
    logic       wd_fire;

    rr_pick4 u_pick (
        .req      (m_cyc_i),
        .ptr      (ptr_q),
        .gnt_next (pick_gnt),
        .idx      (pick_idx)
    );

    assign in_grant = (state_q == GRANT);
    assign gnt_cyc  = in_grant && m_cyc_i[idx_q];
    assign gnt_stb  = in_grant && m_stb_i[idx_q];

    // Ack in the same cycle wins over a timeout.
    assign wd_fire = WdEnable && gnt_stb && !s_ack_i && (wd_cnt_q == WdLast);

    // Grant FSM
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_d = GRANT;
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                end
            end
            GRANT: begin
                // No re-arbitration here: release always costs one idle cycle.
                if (!gnt_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Watchdog counts stalled strobe cycles of the current transfer.
    always_comb begin
        if (!WdEnable || !gnt_stb || s_ack_i || wd_fire || (state_d != GRANT)) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Slave-side mux; everything held at 0 while idle.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (in_grant) begin
            s_adr_o = m_adr_i[int'(idx_q)*adr_width +: adr_width];
            s_dat_o = m_dat_i[int'(idx_q)*32 +: 32];
            s_sel_o = m_sel_i[int'(idx_q)*4 +: 4];
            s_we_o  = m_we_i[idx_q];
            s_cyc_o = gnt_cyc;
            s_stb_o = gnt_stb && !wd_fire;
        end
    end

    assign m_dat_o = s_dat_i;
    assign m_ack_o = {NMASTERS{s_ack_i}} & gnt_q & m_stb_i;
    assign m_err_o = {NMASTERS{wd_fire}} & gnt_q;
    assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
//   Directed bench for wb_rr_arbiter. Main DUT uses timeout_cycles=8; a second
//   instance with timeout_cycles=0 shares the inputs to show the watchdog off.
module tb_wb_rr_arbiter;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  m_adr = '0;
    logic [127:0]  m_dat = '0;
    logic [15:0]   m_sel = '0;
    logic [3:0]    m_we  = '0;
    logic [3:0]    m_cyc = '0;
    logic [3:0]    m_stb = '0;
    logic [31:0]   s_dat_in = '0;
    logic          s_ack = 1'b0;

    logic [31:0]   m_dat_out;
    logic [3:0]    m_ack, m_err, gnt;
    logic [31:0]   s_adr, s_dat_out;
    logic [3:0]    s_sel;
    logic          s_we, s_cyc, s_stb;

    logic [31:0]   m_dat_out0;
    logic [3:0]    m_ack0, m_err0, gnt0;
    logic [31:0]   s_adr0, s_dat_out0;
    logic [3:0]    s_sel0;
    logic          s_we0, s_cyc0, s_stb0;

    int n_checks = 0;
    int n_err    = 0;
    logic err0_seen;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.adr_width(32), .timeout_cycles(8), .cnt_width(16)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_out), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_adr_o(s_adr), .s_dat_o(s_dat_out), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb),
        .s_dat_i(s_dat_in), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    wb_rr_arbiter #(.adr_width(32), .timeout_cycles(0), .cnt_width(16)) dut0 (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_out0), .m_ack_o(m_ack0), .m_err_o(m_err0),
        .s_adr_o(s_adr0), .s_dat_o(s_dat_out0), .s_sel_o(s_sel0), .s_we_o(s_we0),
        .s_cyc_o(s_cyc0), .s_stb_o(s_stb0),
        .s_dat_i(s_dat_in), .s_ack_i(s_ack), .gnt_o(gnt0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        int         g;

        // Reset
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_scyc", s_cyc, 1'b0);
        chk("rst_ack", m_ack, 4'b0000);
        chk("rst_err", m_err, 4'b0000);

        // Single master read on m1
        m_adr[32 +: 32] = 32'h4000_0010;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        #1;
        chk("single_scyc_pre", s_cyc, 1'b0);
        tick();
        chk("single_gnt", gnt, 4'b0010);
        chk("single_scyc", s_cyc, 1'b1);
        chk("single_adr", s_adr, 32'h4000_0010);
        chk("single_noack1", m_ack, 4'b0000);
        tick();
        chk("single_noack2", m_ack, 4'b0000);
        tick();
        s_ack = 1'b1;
        s_dat_in = 32'hDEAD_BEEF;
        #1;
        chk("single_ack", m_ack, 4'b0010);
        chk("single_dat", m_dat_out, 32'hDEAD_BEEF);
        tick();
        s_ack = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        #1;
        chk("single_ack_once", m_ack, 4'b0000);
        chk("single_gnt_hold", gnt, 4'b0010);
        tick();
        chk("single_release", gnt, 4'b0000);

        // Contention from a fresh reset: order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cyc = 4'b1111;
        m_stb = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            exp_g = 4'b0001 << g;
            chk("cont_gnt", gnt, exp_g);
            s_ack = 1'b1;
            #1;
            chk("cont_ack", m_ack, exp_g);
            tick();
            s_ack = 1'b0;
            m_cyc[g] = 1'b0;
            m_stb[g] = 1'b0;
            #1;
            chk("cont_hold", gnt, exp_g);
            chk("cont_noack", m_ack, 4'b0000);
            tick();
            m_cyc[g] = 1'b1;
            m_stb[g] = 1'b1;
            #1;
            chk("cont_bubble", gnt, 4'b0000);
            chk("cont_bubble_scyc", s_cyc, 1'b0);
            tick();
        end
        chk("cont_next", gnt, 4'b0010);
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();

        // Atomic hold: m1 4-beat write burst while m0 waits (ptr is now 2)
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_we[1]  = 1'b1;
        m_sel[4 +: 4]   = 4'hC;
        m_dat[32 +: 32] = 32'h1234_5678;
        tick();
        chk("atom_gnt_first", gnt, 4'b0010);
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        s_ack = 1'b1;
        #1;
        chk("atom_wdat", s_dat_out, 32'h1234_5678);
        chk("atom_sel", s_sel, 4'hC);
        chk("atom_we", s_we, 1'b1);
        for (int b = 0; b < 4; b++) begin
            chk("atom_gnt", gnt, 4'b0010);
            chk("atom_ack", m_ack, 4'b0010);
            tick();
        end
        s_ack = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        m_we[1]  = 1'b0;
        #1;
        chk("atom_hold_end", gnt, 4'b0010);
        tick();
        chk("atom_bubble", gnt, 4'b0000);
        tick();
        chk("atom_m0", gnt, 4'b0001);
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();

        // Watchdog: m0 stalls, ERR on the 8th strobe cycle
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        tick();
        chk("wd_gnt", gnt, 4'b0001);
        for (int c = 1; c <= 7; c++) begin
            chk("wd_pre_err", m_err, 4'b0000);
            chk("wd_pre_stb", s_stb, 1'b1);
            tick();
        end
        chk("wd_fire_err", m_err, 4'b0001);
        chk("wd_fire_stb", s_stb, 1'b0);
        chk("wd0_fire_stb", s_stb0, 1'b1);
        tick();
        chk("wd_after_err", m_err, 4'b0000);
        chk("wd_after_stb", s_stb, 1'b1);
        err0_seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (m_err0 != 4'b0000) err0_seen = 1'b1;
            tick();
        end
        chk("wd0_never_err", err0_seen, 1'b0);
        chk("wd_gnt_kept", gnt, 4'b0001);
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();

        // Ack/timeout race: ack on the 8th strobe cycle wins
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        tick();
        chk("race_gnt", gnt, 4'b0001);
        for (int c = 1; c <= 7; c++) tick();
        s_ack = 1'b1;
        #1;
        chk("race_ack", m_ack, 4'b0001);
        chk("race_err", m_err, 4'b0000);
        chk("race_stb", s_stb, 1'b1);
        s_ack = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();

        // Reset in the middle of an m2 transfer; m0 then wins from ptr 0
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        tick();
        chk("rmid_gnt", gnt, 4'b0100);
        s_ack = 1'b1;
        #1;
        chk("rmid_ack", m_ack, 4'b0100);
        rst = 1'b1;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        tick();
        chk("rmid_gnt_clr", gnt, 4'b0000);
        chk("rmid_scyc", s_cyc, 1'b0);
        chk("rmid_sstb", s_stb, 1'b0);
        chk("rmid_ack_clr", m_ack, 4'b0000);
        chk("rmid_err_clr", m_err, 4'b0000);
        rst = 1'b0;
        s_ack = 1'b0;
        tick();
        chk("rmid_m0_first", gnt, 4'b0001);
        m_cyc = '0;
        m_stb = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
